quad_debounce: RTL and testbench

Four-channel input conditioner that feeds the 4-input AND combiner (`in[3:0]`). Each raw asynchronous contact or sensor line is synchronized into the clock domain and debounced. A channel's level reaches `out` only after it has held steady for a programmable number of cycles. The block also reports per-channel edge pulses and a global "no change pending" flag, so downstream logic knows when the AND result is settled.

---
 rtl/quad_debounce.sv | 84 ++++++++
 tb/tb_quad_debounce.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/quad_debounce.sv
// quad_debounce: four independent synchronize-and-debounce channels feeding
// the AND4 combiner. Each channel's level reaches `out` only after its
// synchronized value has differed from `out` for DEB_CYCLES consecutive
// cycles. Per-channel rise/fall pulses are registered. `stable` reports that
// no channel has a change pending.
module quad_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in,
    output logic [3:0] out,
    output logic [3:0] rise,
    output logic [3:0] fall,
    output logic       stable
);

    // Per-channel state: IDLE means the counter is zero, PEND means a
    // deviation is being qualified.
    localparam logic IDLE = 1'b0;
    localparam logic PEND = 1'b1;

    // Terminal count. When it is reached the flip happens on that edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [3:0] pend;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic             s1_reg;
            logic             s2_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             out_reg;
            logic             rise_reg;
            logic             fall_reg;
            logic             state;

            // The state is fully determined by the counter. With
            // DEB_CYCLES=1 the counter never leaves zero, so the channel
            // never enters PEND.
            assign state = (cnt_reg != '0) ? PEND : IDLE;

            // Synchronize the raw input, qualify deviations, and flip `out`
            // together with a one-cycle edge pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg   <= 1'b0;
                    s2_reg   <= 1'b0;
                    cnt_reg  <= '0;
                    out_reg  <= 1'b0;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    s1_reg   <= in[gi];
                    s2_reg   <= s1_reg;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                    if (s2_reg == out_reg) begin
                        // Glitch return or already settled.
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        out_reg  <= s2_reg;
                        cnt_reg  <= '0;
                        rise_reg <= s2_reg;
                        fall_reg <= ~s2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign out[gi]  = out_reg;
            assign rise[gi] = rise_reg;
            assign fall[gi] = fall_reg;
            assign pend[gi] = (state == PEND);
        end
    endgenerate

    // Settled when no channel is mid-qualification.
    assign stable = ~|pend;

endmodule

// File: tb/tb_quad_debounce.sv
// tb_quad_debounce: directed checks of quad_debounce with DEB_CYCLES=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_quad_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       stable;

    int n_checks;
    int n_fail;
    bit saw_unstable;

    quad_debounce #(
        .DEB_CYCLES(4),
        .CNT_W     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out),
        .rise  (rise),
        .fall  (fall),
        .stable(stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        saw_unstable = 1'b0;
        rst_n        = 1'b0;
        in           = 4'hF;

        // Reset held with all inputs high.
        repeat (3) tick();
        check_eq("rst_out", 32'(out), 32'h0);
        check_eq("rst_rise", 32'(rise), 32'h0);
        check_eq("rst_fall", 32'(fall), 32'h0);
        check_eq("rst_stable", 32'(stable), 32'h1);
        $display("txn reset_hold out=%h stable=%b", out, stable);

        // Release: edge 1 = k, out flips at edge 6, stable low after edges 3..5.
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check_eq($sformatf("rel_out_%0d", n), 32'(out), (n >= 6) ? 32'hF : 32'h0);
            check_eq($sformatf("rel_rise_%0d", n), 32'(rise), (n == 6) ? 32'hF : 32'h0);
            check_eq($sformatf("rel_stable_%0d", n), 32'(stable), (n >= 3 && n <= 5) ? 32'h0 : 32'h1);
        end
        $display("txn release out=%h", out);

        // Bring all channels back to 0.
        in = 4'h0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check_eq($sformatf("clr_fall_%0d", n), 32'(fall), (n == 6) ? 32'hF : 32'h0);
        end
        check_eq("clr_out", 32'(out), 32'h0);
        $display("txn clear out=%h", out);

        // Glitch: in[2] high for 3 cycles never reaches out.
        in = 4'b0100;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 3) in = 4'b0000;
            check_eq($sformatf("gl_out_%0d", n), 32'(out), 32'h0);
            check_eq($sformatf("gl_rise_%0d", n), 32'(rise), 32'h0);
            check_eq($sformatf("gl_stable_%0d", n), 32'(stable), (n >= 3 && n <= 5) ? 32'h0 : 32'h1);
        end
        $display("txn glitch out=%h", out);

        // Exact threshold on in[1].
        in = 4'b0010;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check_eq($sformatf("th_out_%0d", n), 32'(out), (n >= 6) ? 32'h2 : 32'h0);
            check_eq($sformatf("th_rise_%0d", n), 32'(rise), (n == 6) ? 32'h2 : 32'h0);
            check_eq($sformatf("th_stable_%0d", n), 32'(stable), (n >= 3 && n <= 5) ? 32'h0 : 32'h1);
        end
        $display("txn threshold out=%h", out);

        in = 4'h0;
        repeat (8) tick();
        check_eq("th_back_out", 32'(out), 32'h0);

        // Simultaneous flips, up then down.
        in = 4'hF;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check_eq($sformatf("sim_up_out_%0d", n), 32'(out), (n >= 6) ? 32'hF : 32'h0);
            check_eq($sformatf("sim_up_rise_%0d", n), 32'(rise), (n == 6) ? 32'hF : 32'h0);
            check_eq($sformatf("sim_up_fall_%0d", n), 32'(fall), 32'h0);
        end
        $display("txn simul_rise out=%h", out);
        in = 4'h0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check_eq($sformatf("sim_dn_out_%0d", n), 32'(out), (n >= 6) ? 32'h0 : 32'hF);
            check_eq($sformatf("sim_dn_fall_%0d", n), 32'(fall), (n == 6) ? 32'hF : 32'h0);
            check_eq($sformatf("sim_dn_rise_%0d", n), 32'(rise), 32'h0);
        end
        $display("txn simul_fall out=%h", out);

        // Reset mid-count on in[0].
        in = 4'b0001;
        repeat (3) tick();
        check_eq("mid_pending", 32'(stable), 32'h0);
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_out", 32'(out), 32'h0);
        check_eq("mid_rst_stable", 32'(stable), 32'h1);
        #1;
        rst_n = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            check_eq($sformatf("mid_out_%0d", n), 32'(out), (n >= 6) ? 32'h1 : 32'h0);
            check_eq($sformatf("mid_rise_%0d", n), 32'(rise), (n == 6) ? 32'h1 : 32'h0);
        end
        $display("txn reset_mid out=%h", out);

        // Chatter on in[3], toggling every 2 cycles for 40 cycles.
        for (int n = 0; n < 40; n++) begin
            if (n % 2 == 0) in[3] = ~in[3];
            tick();
            if (!stable) saw_unstable = 1'b1;
            check_eq($sformatf("ch_out_%0d", n), 32'(out), 32'h1);
            check_eq($sformatf("ch_rise_%0d", n), 32'(rise[3]), 32'h0);
            check_eq($sformatf("ch_fall_%0d", n), 32'(fall[3]), 32'h0);
        end
        check_eq("ch_saw_pending", 32'(saw_unstable), 32'h1);
        repeat (6) tick();
        check_eq("ch_end_out", 32'(out), 32'h1);
        check_eq("ch_end_stable", 32'(stable), 32'h1);
        $display("txn chatter out=%h", out);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
